tnn_neuron_seq: RTL and testbench
=================================

# tnn_neuron_seq

Sequential, parametrised ternary-weight threshold neuron for the approximate TNN classifier library. It accepts one packed vector of N_IN unsigned W-bit features over a valid/ready handshake and accumulates a ternary-weighted sum, LANES features per cycle. It thresholds the sum into a single class bit and returns the bit and the sum over a second valid/ready handshake. It is the time-multiplexed, configurable successor to the fixed-width single-shot combinational classifier cores, and adds optional LSB truncation for accuracy/area exploration.

## Interface
- N_IN, 5: number of input features.
- W, 2: feature width in bits, unsigned.
- LANES, 1: features accumulated per cycle, 1..N_IN.
- WPOS, 5'b00000: N_IN-bit mask. Bit i set means weight(i) = +1.
- WNEG, 5'b00000: N_IN-bit mask. Bit i set means weight(i) = −1.
- THRESH, 0: signed decision threshold, ACC_W bits.
- DROP_LSB, 0: number of feature LSBs forced to zero before weighting, 0..W.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  the feature vector is valid.
- in_ready  out  1  the block can accept a vector.
- in_data  in  N_IN*W  feature i is in_data[i*W +: W].
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_class  out  1  result bit: 1 when out_sum ≥ THRESH, signed compare.
- out_sum  out  ACC_W  signed weighted sum.

ACC_W = $clog2(N_IN*(2^W−1)+1)+1.

## Operation
- Feature preprocessing: f'(i) = f(i) & ~((1<<DROP_LSB)−1). Magnitude is kept; low bits are cleared.
- Weighting: term(i) is +f'(i) when WPOS[i] is set, −f'(i) when WNEG[i] is set, and 0 otherwise.
- Illegal weights: a bit set in both WPOS and WNEG fails an elaboration assertion. If simulation continues, that bit is treated as weight 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, clear acc, set idx=0, go to ACC.
  - ACC: each cycle, acc += sum of term(idx..idx+LANES−1); idx += LANES. Lanes with index ≥ N_IN contribute 0. After the K-th ACC cycle, with K = ceil(N_IN/LANES), register out_sum and out_class and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_data is ignored outside IDLE. The input vector is latched, so the producer may change in_data after the handshake.
- In DONE, the outputs hold stable for any duration of out_ready low.
- Arithmetic: all sums are signed ACC_W bits. The width guarantees no overflow for any weights or inputs.

## Timing
- Reset values: state IDLE, acc=0, idx=0, out_valid=0, out_class=0, out_sum=0. in_ready=0 while rst is high and 1 in the cycle after rst falls.
- Reset mid-operation: rst in ACC or DONE aborts the transaction. No result is emitted for the aborted vector.
- Latency: input handshake at cycle t; ACC occupies t+1..t+K; out_valid rises at t+K+1.
- Overlap: none. The block is in IDLE only in the cycle after the output handshake, so the next input is accepted no earlier than that cycle.
- Throughput: one result per K+2 cycles when both handshakes complete immediately.
- Registered outputs: out_valid, out_class and out_sum are registered. in_ready is decoded from state only, with no combinational path from any input.

## Structure
- Package tnn_pkg holds:
  - the state enum {IDLE, ACC, DONE};
  - the function acc_width(n, w);
  - the function ceil_div(a, b).
- Sub-module tnn_lane_adder: combinational LANES-wide ternary-weighted adder.
  - Inputs: the LANES feature slices, weight-sign masks and lane-valid bits.
  - Output: a signed ACC_W partial sum.
- The top level holds the FSM, the latched vector, idx and the accumulator.

## Test plan
- Case 1. N_IN=5, W=2, LANES=1, WPOS=5'b11111, WNEG=0, THRESH=6, all features 3 → out_sum=15 and out_class=1, with out_valid rising 6 cycles after the input handshake.
- Case 2. WPOS=5'b00011, WNEG=5'b11100, THRESH=4, features {3,3,1,1,1} → out_sum=3 and out_class=0. With THRESH=3, out_class=1.
- Case 3. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, out_sum and out_class stay stable and in_ready stays 0. The next input is accepted the cycle after out_ready=1.
- Case 4. LANES=2, N_IN=5, case-1 stimulus → K=3, out_valid rises 4 cycles after the handshake, out_sum=15. The padded lane contributes 0.
- Case 5. DROP_LSB=1, all weights +1, features {1,3,2,1,3} → effective features {0,2,2,0,2}, so out_sum=6.
- Case 6. Assert rst in the second ACC cycle → the next cycle is IDLE with out_valid=0 and out_sum=0, and in_ready=1 after rst falls. A fresh vector then yields a correct result with no stale accumulator contribution.

Source files
------------

// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared types and sizing helpers for the ternary threshold neuron
package tnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } tnn_state_e;

    // Signed width that holds the full +/- sum of n unsigned w-bit features.
    function automatic int acc_width(input int n, input int w);
        return $clog2(n * ((1 << w) - 1) + 1) + 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/tnn_neuron_seq_if.sv
// rtl/tnn_neuron_seq_if.sv - feature-in / result-out handshake bundle for the neuron
interface tnn_neuron_seq_if
    import tnn_pkg::*;
#(
    parameter int N_IN = 5,
    parameter int W    = 2
);
    localparam int ACC_W = acc_width(N_IN, W);

    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN*W-1:0]       in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_class;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class, out_sum
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class, out_sum
    );

endinterface

// File: rtl/tnn_lane_adder.sv
// rtl/tnn_lane_adder.sv - combinational LANES-wide ternary-weighted partial sum
module tnn_lane_adder #(
    parameter int LANES    = 1,
    parameter int W        = 2,
    parameter int ACC_W    = 5,
    parameter int DROP_LSB = 0
) (
    input  logic [LANES*W-1:0]      feat,
    input  logic [LANES-1:0]        pos,
    input  logic [LANES-1:0]        neg,
    input  logic [LANES-1:0]        lane_valid,
    output logic signed [ACC_W-1:0] sum
);
    // Bits that survive truncation; DROP_LSB == W clears the feature entirely.
    localparam logic [W-1:0] KEEP = ~W'((1 << DROP_LSB) - 1);

    logic [W-1:0]            f;
    logic signed [ACC_W-1:0] mag;

    // Add or subtract each truncated lane feature according to its weight sign.
    always_comb begin
        sum = '0;
        f   = '0;
        mag = '0;
        for (int l = 0; l < LANES; l++) begin
            f   = feat[l*W +: W] & KEEP;
            mag = ACC_W'(f);
            if (lane_valid[l]) begin
                if (pos[l]) begin
                    sum = sum + mag;
                end else if (neg[l]) begin
                    sum = sum - mag;
                end
            end
        end
    end

endmodule

// File: rtl/tnn_neuron_seq.sv
// rtl/tnn_neuron_seq.sv - sequential ternary-weight threshold neuron, LANES features per cycle
module tnn_neuron_seq
    import tnn_pkg::*;
#(
    parameter int              N_IN     = 5,
    parameter int              W        = 2,
    parameter int              LANES    = 1,
    parameter logic [N_IN-1:0] WPOS     = '0,
    parameter logic [N_IN-1:0] WNEG     = '0,
    parameter int              THRESH   = 0,
    parameter int              DROP_LSB = 0
) (
    input  logic           clk,
    input  logic           rst,
    tnn_neuron_seq_if.slave bus
);
    localparam int ACC_W = acc_width(N_IN, W);
    localparam int K     = ceil_div(N_IN, LANES);
    localparam int PAD_N = K * LANES;
    localparam int IDX_W = $clog2(PAD_N + 1);

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'((K - 1) * LANES);
    localparam logic [IDX_W-1:0]        STEP     = IDX_W'(LANES);
    localparam logic signed [ACC_W-1:0] THRESH_S = ACC_W'(THRESH);

    // A feature flagged both +1 and -1 is treated as weight 0.
    localparam logic [N_IN-1:0] POS_EFF = WPOS & ~WNEG;
    localparam logic [N_IN-1:0] NEG_EFF = WNEG & ~WPOS;

    if ((WPOS & WNEG) != '0) begin : g_weight_conflict
        $error("tnn_neuron_seq: WPOS and WNEG overlap");
    end

    tnn_state_e state_q, state_d;
    logic       in_ready_q;
    logic       accept;
    logic       finish;

    logic [PAD_N*W-1:0]      vec_q;
    logic [PAD_N-1:0]        pos_q;
    logic [PAD_N-1:0]        neg_q;
    logic [PAD_N-1:0]        lv_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] part;
    logic signed [ACC_W-1:0] acc_sum;

    logic                    out_valid_q;
    logic                    out_class_q;
    logic signed [ACC_W-1:0] out_sum_q;

    tnn_lane_adder #(
        .LANES    (LANES),
        .W        (W),
        .ACC_W    (ACC_W),
        .DROP_LSB (DROP_LSB)
    ) u_lane_adder (
        .feat       (vec_q[LANES*W-1:0]),
        .pos        (pos_q[LANES-1:0]),
        .neg        (neg_q[LANES-1:0]),
        .lane_valid (lv_q[LANES-1:0]),
        .sum        (part)
    );

    assign acc_sum = acc_q + part;

    // Next-state decode plus the load/finish strobes for the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (idx_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; in_ready is registered alongside it so it stays low through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    // Latch the padded vector on accept, then shift one lane group out per ACC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            pos_q <= '0;
            neg_q <= '0;
            lv_q  <= '0;
            idx_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            vec_q <= (PAD_N*W)'(bus.in_data);
            pos_q <= PAD_N'(POS_EFF);
            neg_q <= PAD_N'(NEG_EFF);
            lv_q  <= PAD_N'({N_IN{1'b1}});
            idx_q <= '0;
            acc_q <= '0;
        end else if (state_q == ACC) begin
            vec_q <= vec_q >> (LANES * W);
            pos_q <= pos_q >> LANES;
            neg_q <= neg_q >> LANES;
            lv_q  <= lv_q >> LANES;
            idx_q <= idx_q + STEP;
            acc_q <= acc_sum;
        end
    end

    // Result registers: captured on the last ACC cycle, held until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            out_sum_q   <= '0;
        end else if (finish) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_sum;
            out_class_q <= (acc_sum >= THRESH_S);
        end else if ((state_q == DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// tb/tb_tnn_neuron_seq.sv - directed-vector bench for tnn_neuron_seq across five configurations
module tb_tnn_neuron_seq;

    localparam int NDUT = 5;
    // 0: all +1, T=6 | 1: ++---, T=4 | 2: ++---, T=3 | 3: LANES=2, all +1 | 4: DROP_LSB=1, T=7
    localparam int         LANES_T  [NDUT] = '{1, 1, 1, 2, 1};
    localparam logic [4:0] WPOS_T   [NDUT] = '{5'b11111, 5'b00011, 5'b00011, 5'b11111, 5'b11111};
    localparam logic [4:0] WNEG_T   [NDUT] = '{5'b00000, 5'b11100, 5'b11100, 5'b00000, 5'b00000};
    localparam int         THRESH_T [NDUT] = '{6, 4, 3, 6, 7};
    localparam int         DROP_T   [NDUT] = '{0, 0, 0, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_v  [NDUT];
    logic [9:0] in_data_v   [NDUT];
    logic       out_ready_v [NDUT];
    logic       in_ready_w  [NDUT];
    logic       out_valid_w [NDUT];
    logic       out_class_w [NDUT];
    logic [4:0] out_sum_w   [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        tnn_neuron_seq_if #(.N_IN(5), .W(2)) bus ();

        assign bus.in_valid   = in_valid_v[g];
        assign bus.in_data    = in_data_v[g];
        assign bus.out_ready  = out_ready_v[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign out_class_w[g] = bus.out_class;
        assign out_sum_w[g]   = bus.out_sum;

        tnn_neuron_seq #(
            .N_IN     (5),
            .W        (2),
            .LANES    (LANES_T[g]),
            .WPOS     (WPOS_T[g]),
            .WNEG     (WNEG_T[g]),
            .THRESH   (THRESH_T[g]),
            .DROP_LSB (DROP_T[g])
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a vector, then count cycles from the handshake cycle until out_valid is seen.
    task automatic send(input int d, input logic [9:0] data, input int exp_lat, input string tag);
        int lat;
        int waited;
        in_valid_v[d] = 1'b1;
        in_data_v[d]  = data;
        waited = 0;
        while (!in_ready_w[d] && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready_w[d]), 32'd1);
        tick();
        in_valid_v[d] = 1'b0;
        in_data_v[d]  = ~data;
        lat = 1;
        while (!out_valid_w[d] && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Check the held result, complete the output handshake, and confirm return to IDLE.
    task automatic collect(input int d, input logic [4:0] exp_sum, input logic exp_cls, input string tag);
        chk({tag, "_sum"}, 32'(out_sum_w[d]), 32'(exp_sum));
        chk({tag, "_class"}, 32'(out_class_w[d]), 32'(exp_cls));
        out_ready_v[d] = 1'b1;
        tick();
        out_ready_v[d] = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid_w[d]), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready_w[d]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            in_valid_v[i]  = 1'b0;
            in_data_v[i]   = '0;
            out_ready_v[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready_w[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("rst_out_sum", 32'(out_sum_w[0]), 32'd0);
        chk("rst_out_class", 32'(out_class_w[0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready_w[0]), 32'd1);

        // All features 3, all weights +1: 15 >= 6
        send(0, 10'h3FF, 6, "c1");
        collect(0, 5'd15, 1'b1, "c1");

        // Features {3,3,1,1,1} with ++---: 3 < 4, then 3 >= 3
        send(1, {2'd1, 2'd1, 2'd1, 2'd3, 2'd3}, 6, "c2a");
        collect(1, 5'd3, 1'b0, "c2a");
        send(2, {2'd1, 2'd1, 2'd1, 2'd3, 2'd3}, 6, "c2b");
        collect(2, 5'd3, 1'b1, "c2b");

        // Features {0,0,3,3,3} with ++---: -9, signed compare must give class 0
        send(1, {2'd3, 2'd3, 2'd3, 2'd0, 2'd0}, 6, "neg");
        collect(1, 5'b10111, 1'b0, "neg");

        // LANES=2: K=3, padded sixth lane contributes nothing
        send(3, 10'h3FF, 4, "c4");
        collect(3, 5'd15, 1'b1, "c4");

        // DROP_LSB=1, features {1,3,2,1,3} -> {0,2,2,0,2} = 6 < 7
        send(4, {2'd3, 2'd1, 2'd2, 2'd3, 2'd1}, 6, "c5");
        collect(4, 5'd6, 1'b0, "c5");

        // Backpressure: features {1,3,0,1,2} = 7, hold out_ready low 5 cycles with a new vector pending
        send(0, {2'd2, 2'd1, 2'd0, 2'd3, 2'd1}, 6, "c3");
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 10'h155;
        for (int i = 0; i < 5; i++) begin
            chk("c3_hold_valid", 32'(out_valid_w[0]), 32'd1);
            chk("c3_hold_sum", 32'(out_sum_w[0]), 32'd7);
            chk("c3_hold_class", 32'(out_class_w[0]), 32'd1);
            chk("c3_hold_in_ready", 32'(in_ready_w[0]), 32'd0);
            tick();
        end
        collect(0, 5'd7, 1'b1, "c3");
        // Pending vector (all ones = 5) is accepted right away
        send(0, 10'h155, 6, "c3n");
        collect(0, 5'd5, 1'b0, "c3n");

        // Reset during the second ACC cycle aborts the transaction
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 10'h3FF;
        chk("c6_in_ready", 32'(in_ready_w[0]), 32'd1);
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("c6_rst_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("c6_rst_out_sum", 32'(out_sum_w[0]), 32'd0);
        chk("c6_rst_in_ready", 32'(in_ready_w[0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("c6_post_in_ready", 32'(in_ready_w[0]), 32'd1);
        tick();
        chk("c6_no_result", 32'(out_valid_w[0]), 32'd0);
        // Fresh vector {1,0,2,0,3} = 6 >= 6 with no leftover accumulator
        send(0, {2'd3, 2'd0, 2'd2, 2'd0, 2'd1}, 6, "c6f");
        collect(0, 5'd6, 1'b1, "c6f");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
